// File: rtl/input_snapshot_regs.sv
// input_snapshot_regs
//   Samples every player's buttons, analog stick, paddle and spinner position once per frame
//   on the rising edge of vblank, so the CPU always sees one coherent frame of input. Spinner
//   deltas are accumulated live into absolute positions. Per-player button-change flags and
//   a frame counter are kept. Everything is exposed on a byte-wide read port with one cycle
//   of read latency.
//
// Parameters
//   PLAYERS  number of player channels (1..15)
//   BUTTONS  button bits per player (1..32)
//   SPIN_W   spinner position accumulator width (9..16)
//
// Ports
//   clk_sys         system clock
//   reset           synchronous, active-high reset
//   vblank          vertical blank level; its rising edge takes a snapshot
//   joystick        buttons, player p at [p*BUTTONS +: BUTTONS]
//   analog          per player 16 bits: Y [15:8], X [7:0]
//   paddle          per player 8-bit paddle position
//   spinner         per player 16 bits: [7:0] signed delta, [8] event toggle, [15:9] ignored
//   cpu_rd          one-cycle read strobe
//   cpu_addr        read address (player p block at p*16, globals at 0xF0..0xF4)
//   cpu_dout        read data, presented the cycle after cpu_rd
//   cpu_dout_valid  high for the cycle that carries read data
//   frame_strobe    one-cycle pulse in the first cycle the new snapshot is readable
//
// Build option
//   INPUT_EDGE_LATCH_EN  when defined, adds a sticky per-player "pressed" latch that is
//                        readable (and cleared byte-wise) at player offsets +10..+13.

module input_snapshot_regs #(
  parameter int unsigned PLAYERS = 6,
  parameter int unsigned BUTTONS = 32,
  parameter int unsigned SPIN_W  = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       vblank,
  input  logic [BUTTONS*PLAYERS-1:0] joystick,
  input  logic [16*PLAYERS-1:0]      analog,
  input  logic [8*PLAYERS-1:0]       paddle,
  input  logic [16*PLAYERS-1:0]      spinner,
  input  logic                       cpu_rd,
  input  logic [7:0]                 cpu_addr,
  output logic [7:0]                 cpu_dout,
  output logic                       cpu_dout_valid,
  output logic                       frame_strobe
);

  logic               vblank_q;
  logic               snap;

  // Snapshot registers
  logic [BUTTONS-1:0] btn_q  [PLAYERS];
  logic [15:0]        ana_q  [PLAYERS];
  logic [7:0]         pad_q  [PLAYERS];
  logic [SPIN_W-1:0]  spin_q [PLAYERS];

  // Live spinner accumulators
  logic [SPIN_W-1:0]  pos_q  [PLAYERS];
  logic [SPIN_W-1:0]  pos_d  [PLAYERS];
  logic [PLAYERS-1:0] tog_q;

  logic [14:0]        changed_q;
  logic [14:0]        changed_d;
  logic [14:0]        changed_set;
  logic [14:0]        changed_clr;
  logic [7:0]         frame_cnt_q;

  logic [7:0]         rd_data;
  logic [31:0]        btn_ext;
  logic [15:0]        spin_ext;
  logic [7*PLAYERS-1:0] unused_spin_hi;

  assign snap = vblank & ~vblank_q;

  // Spinner accumulation runs every cycle; an event is a change of the toggle bit.
  always_comb begin
    unused_spin_hi = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      pos_d[p] = pos_q[p];
      if (spinner[p*16+8] != tog_q[p]) begin
        pos_d[p] = pos_q[p] + {{(SPIN_W-8){spinner[p*16+7]}}, spinner[p*16 +: 8]};
      end
      unused_spin_hi[p*7 +: 7] = spinner[p*16+9 +: 7];
    end
  end

  // Clear-on-read is applied first so a same-cycle snapshot set wins.
  always_comb begin
    changed_set = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      changed_set[p] = snap && (joystick[p*BUTTONS +: BUTTONS] != btn_q[p]);
    end
    changed_d = (changed_q & ~changed_clr) | changed_set;
  end

`ifdef INPUT_EDGE_LATCH_EN
  logic [31:0] edge_q   [PLAYERS];
  logic [31:0] edge_d   [PLAYERS];
  logic [31:0] edge_clr [PLAYERS];

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      edge_d[p] = edge_q[p] & ~edge_clr[p];
      if (snap) begin
        edge_d[p] = edge_d[p] | 32'(joystick[p*BUTTONS +: BUTTONS] & ~btn_q[p]);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < PLAYERS; p++) begin
      if (reset) begin
        edge_q[p] <= '0;
      end else begin
        edge_q[p] <= edge_d[p];
      end
    end
  end
`endif

  // Read decode works on registered snapshot state only, so a read in the snapshot cycle
  // returns the previous frame and a clear-on-read returns the pre-clear value.
  always_comb begin
    rd_data     = '0;
    changed_clr = '0;
    btn_ext     = '0;
    spin_ext    = '0;
`ifdef INPUT_EDGE_LATCH_EN
    for (int p = 0; p < PLAYERS; p++) begin
      edge_clr[p] = '0;
    end
`endif
    if (cpu_addr[7:4] == 4'hF) begin
      case (cpu_addr[3:0])
        4'h0: begin
          rd_data = changed_q[7:0];
          if (cpu_rd) changed_clr[7:0] = '1;
        end
        4'h1: begin
          rd_data = {1'b0, changed_q[14:8]};
          if (cpu_rd) changed_clr[14:8] = '1;
        end
        4'h2:    rd_data = frame_cnt_q;
        4'h3:    rd_data = 8'(PLAYERS);
        4'h4:    rd_data = 8'(BUTTONS);
        default: rd_data = '0;
      endcase
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (cpu_addr[7:4] == 4'(p)) begin
          btn_ext  = 32'(btn_q[p]);
          spin_ext = 16'(spin_q[p]);
          case (cpu_addr[3:0])
            4'd0:    rd_data = btn_ext[7:0];
            4'd1:    rd_data = btn_ext[15:8];
            4'd2:    rd_data = btn_ext[23:16];
            4'd3:    rd_data = btn_ext[31:24];
            4'd4:    rd_data = ana_q[p][7:0];
            4'd5:    rd_data = ana_q[p][15:8];
            4'd6:    rd_data = pad_q[p];
            4'd7:    rd_data = spin_ext[7:0];
            4'd8:    rd_data = spin_ext[15:8];
`ifdef INPUT_EDGE_LATCH_EN
            4'd10: begin
              rd_data = edge_q[p][7:0];
              if (cpu_rd) edge_clr[p][7:0] = '1;
            end
            4'd11: begin
              rd_data = edge_q[p][15:8];
              if (cpu_rd) edge_clr[p][15:8] = '1;
            end
            4'd12: begin
              rd_data = edge_q[p][23:16];
              if (cpu_rd) edge_clr[p][23:16] = '1;
            end
            4'd13: begin
              rd_data = edge_q[p][31:24];
              if (cpu_rd) edge_clr[p][31:24] = '1;
            end
`endif
            default: rd_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Edge detectors track the live inputs so nothing fires on reset release.
      vblank_q       <= vblank;
      changed_q      <= '0;
      frame_cnt_q    <= '0;
      cpu_dout       <= '0;
      cpu_dout_valid <= 1'b0;
      frame_strobe   <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        btn_q[p]  <= '0;
        ana_q[p]  <= '0;
        pad_q[p]  <= '0;
        spin_q[p] <= '0;
        pos_q[p]  <= '0;
        tog_q[p]  <= spinner[p*16+8];
      end
    end else begin
      vblank_q       <= vblank;
      changed_q      <= changed_d;
      frame_strobe   <= snap;
      cpu_dout_valid <= cpu_rd;
      if (cpu_rd) cpu_dout <= rd_data;
      if (snap) frame_cnt_q <= frame_cnt_q + 8'd1;
      for (int p = 0; p < PLAYERS; p++) begin
        pos_q[p] <= pos_d[p];
        tog_q[p] <= spinner[p*16+8];
        if (snap) begin
          btn_q[p]  <= joystick[p*BUTTONS +: BUTTONS];
          ana_q[p]  <= analog[p*16 +: 16];
          pad_q[p]  <= paddle[p*8 +: 8];
          // pos_d so an event in the snapshot cycle is included.
          spin_q[p] <= pos_d[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_input_snapshot_regs.sv
module tb_input_snapshot_regs;

  localparam int NP = 6;
  localparam int NB = 32;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              vblank;
  logic [NB*NP-1:0]  joystick;
  logic [16*NP-1:0]  analog;
  logic [8*NP-1:0]   paddle;
  logic [16*NP-1:0]  spinner;
  logic              cpu_rd;
  logic [7:0]        cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_dout_valid;
  logic              frame_strobe;

  input_snapshot_regs #(.PLAYERS(NP), .BUTTONS(NB), .SPIN_W(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .vblank         (vblank),
    .joystick       (joystick),
    .analog         (analog),
    .paddle         (paddle),
    .spinner        (spinner),
    .cpu_rd         (cpu_rd),
    .cpu_addr       (cpu_addr),
    .cpu_dout       (cpu_dout),
    .cpu_dout_valid (cpu_dout_valid),
    .frame_strobe   (frame_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  // Behavioural model: the frame as the CPU should see it.
  logic [31:0] m_btn [NP];
  logic [15:0] m_ana [NP];
  logic [7:0]  m_pad [NP];
  int          m_spin[NP];
  int          m_pos [NP];
  logic        m_ref [NP];
  logic [31:0] m_edge[NP];
  logic [14:0] m_changed;
  int          m_frame;
  logic        m_vb_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int blk = int'(a[7:4]);
    int off = int'(a[3:0]);
    logic [31:0] w;
    if (blk == 15) begin
      case (off)
        0: return m_changed[7:0];
        1: return {1'b0, m_changed[14:8]};
        2: return 8'(m_frame);
        3: return 8'(NP);
        4: return 8'(NB);
        default: return 8'h00;
      endcase
    end
    if (blk >= NP) return 8'h00;
    case (off)
      0, 1, 2, 3: begin
        w = m_btn[blk] >> (8 * off);
        return w[7:0];
      end
      4: return m_ana[blk][7:0];
      5: return m_ana[blk][15:8];
      6: return m_pad[blk];
      7: return 8'(m_spin[blk] % 256);
      8: return 8'(m_spin[blk] / 256);
`ifdef INPUT_EDGE_LATCH_EN
      10, 11, 12, 13: begin
        w = m_edge[blk] >> (8 * (off - 10));
        return w[7:0];
      end
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clear(input logic [7:0] a);
    int blk = int'(a[7:4]);
    int off = int'(a[3:0]);
    if (a == 8'hF0) m_changed[7:0] = '0;
    if (a == 8'hF1) m_changed[14:8] = '0;
`ifdef INPUT_EDGE_LATCH_EN
    if (blk < NP && off >= 10 && off <= 13) m_edge[blk] &= ~(32'hFF << (8 * (off - 10)));
`else
    if (blk < 0 || off < 0) m_changed = '0;
`endif
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_btn[p] = '0; m_ana[p] = '0; m_pad[p] = '0; m_spin[p] = 0; m_pos[p] = 0;
      m_edge[p] = '0;
      m_ref[p] = spinner[p*16+8];
    end
    m_changed = '0;
    m_frame = 0;
    m_vb_prev = vblank;
  endtask

  task automatic model_cycle(output bit snap);
    int d;
    logic [31:0] nb;
    if (cpu_rd) begin
      exp_q.push_back('{addr: cpu_addr, data: model_read(cpu_addr)});
      model_clear(cpu_addr);
    end
    for (int p = 0; p < NP; p++) begin
      if (spinner[p*16+8] != m_ref[p]) begin
        d = int'(spinner[p*16 +: 8]);
        if (d > 127) d -= 256;
        m_pos[p] = (m_pos[p] + d + 65536) % 65536;
        m_ref[p] = spinner[p*16+8];
      end
    end
    snap = vblank && !m_vb_prev;
    if (snap) begin
      for (int p = 0; p < NP; p++) begin
        nb = joystick[p*NB +: NB];
        if (nb != m_btn[p]) m_changed[p] = 1'b1;
        m_edge[p] |= nb & ~m_btn[p];
        m_btn[p] = nb;
        m_ana[p] = analog[p*16 +: 16];
        m_pad[p] = paddle[p*8 +: 8];
        m_spin[p] = m_pos[p];
      end
      m_frame = (m_frame + 1) % 256;
    end
    m_vb_prev = vblank;
  endtask

  // One clock cycle: model consumes the inputs currently driven, then the DUT clocks.
  task automatic step();
    bit snap = 0;
    bit in_reset = reset;
    if (in_reset) model_reset();
    else model_cycle(snap);
    @(posedge clk_sys);
    #1;
    if (in_reset) begin
      check("reset_valid", 32'(cpu_dout_valid), 32'd0);
      check("reset_dout", 32'(cpu_dout), 32'd0);
    end
    check("frame_strobe", 32'(frame_strobe), 32'(snap));
  endtask

  task automatic rd(input logic [7:0] a);
    cpu_rd = 1'b1;
    cpu_addr = a;
    step();
    cpu_rd = 1'b0;
  endtask

  task automatic frame();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
  endtask

  task automatic spin_event(input int p, input logic [7:0] delta);
    spinner[p*16 +: 8] = delta;
    spinner[p*16+8] = ~spinner[p*16+8];
    step();
  endtask

  // Monitor: every valid read beat must match the oldest outstanding expectation.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk_sys);
      if (cpu_dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got dout 0x%0h, expected no read data", cpu_dout);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("read_0x%02h", e.addr), 32'(cpu_dout), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    reset = 1'b1; vblank = 1'b0; cpu_rd = 1'b0; cpu_addr = '0;
    joystick = '0; analog = '0; paddle = '0; spinner = '0;
    spinner[8] = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (10) step();
    frame();
    rd(8'h07);
    rd(8'h08);

    // Buttons and change flags
    joystick[31:0] = 32'h0000_0005;
    analog[15:0] = 16'h81_7F;
    paddle[7:0] = 8'hA5;
    frame();
    rd(8'h00); rd(8'h04); rd(8'h05); rd(8'h06);
    rd(8'hF0); rd(8'hF0);

    // Spinner accumulation on player 1, including a negative delta
    spin_event(1, 8'h7F); spin_event(1, 8'h7F); spin_event(1, 8'h7F); spin_event(1, 8'h80);
    frame();
    rd(8'h17); rd(8'h18);

    // Spinner wrap on player 2
    spin_event(2, 8'hFF);
    frame();
    rd(8'h27); rd(8'h28);

    // Event in the snapshot cycle is captured
    spinner[2*16 +: 8] = 8'h03;
    spinner[2*16+8] = ~spinner[2*16+8];
    frame();
    rd(8'h27); rd(8'h28);

    // Snapshot and clear-on-read in the same cycle: set wins, data is pre-clear
    rd(8'hF0);
    joystick[31:0] = 32'h0000_0007;
    vblank = 1'b1;
    rd(8'hF0);
    vblank = 1'b0;
    rd(8'hF0);
    rd(8'hF0);

    // Sticky press latch
    for (int i = 10; i < 14; i++) rd(8'(i));
    joystick[31:0] = 32'h1; frame();
    joystick[31:0] = 32'h3; frame();
    joystick[31:0] = 32'h1; frame();
    rd(8'h0A); rd(8'h0A); rd(8'h0B);

    // Globals and unused space
    rd(8'hF2); rd(8'hF3); rd(8'hF4); rd(8'hF5); rd(8'h09); rd(8'h0F); rd(8'h60); rd(8'hE0);

    // Reset in the middle of a read
    cpu_rd = 1'b1; cpu_addr = 8'h00; reset = 1'b1;
    step();
    reset = 1'b0; cpu_rd = 1'b0;
    step();
    rd(8'h00); rd(8'hF2);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 7) == 0) joystick[p*NB +: NB] = $urandom;
        if ($urandom_range(0, 3) == 0) analog[p*16 +: 16] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) paddle[p*8 +: 8] = 8'($urandom);
        spinner[p*16 +: 8] = 8'($urandom);
        spinner[p*16+9 +: 7] = 7'($urandom);
        if ($urandom_range(0, 1) == 0) spinner[p*16+8] = ~spinner[p*16+8];
      end
      if ($urandom_range(0, 5) == 0) vblank = ~vblank;
      cpu_rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 8'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
        1: a = 8'($urandom_range(8'hF0, 8'hF1));
        2: a = 8'($urandom_range(8'hF0, 8'hFF));
        default: a = 8'($urandom);
      endcase
      cpu_addr = a;
      step();
    end
    cpu_rd = 1'b0;
    vblank = 1'b0;
    repeat (3) step();
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
